// File: rtl/xvc_shift_ctrl.sv
// rtl/xvc_shift_ctrl.sv - splits an XVC shift command into 32-bit JTAG engine chunks and streams back TDO words
module xvc_shift_ctrl #(
    parameter int unsigned C_DONE_TIMEOUT = 65535
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_len_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_tms_i,
    input  logic [31:0] in_tdi_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_tdo_o,
    output logic        out_last_o,
    output logic        jp_en_o,
    output logic [31:0] jp_length_o,
    output logic [31:0] jp_tms_o,
    output logic [31:0] jp_tdi_o,
    input  logic        jp_done_i,
    input  logic [31:0] jp_tdo_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_GAP,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rem;
    logic [31:0] r_cnt;
    logic [31:0] r_len;
    logic [31:0] r_tms;
    logic [31:0] r_tdi;
    logic [31:0] r_tdo;
    logic        r_done;
    logic        r_err;

    logic [31:0] w_cnt_next;
    logic        w_timeout;
    logic [31:0] w_rem_next;
    logic [31:0] w_chunk;
    logic [31:0] w_mask;

    assign w_cnt_next = r_cnt + 32'd1;
    assign w_timeout  = (w_cnt_next >= C_DONE_TIMEOUT);
    assign w_rem_next = r_rem - r_len;
    assign w_chunk    = (r_rem > 32'd32) ? 32'd32 : r_rem;
    // A shift by 32 yields zero, so a full-width chunk keeps every bit.
    assign w_mask     = ~(32'hFFFF_FFFF << r_len);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        cmd_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        jp_en_o     = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            S_IDLE: begin
                // Held low while reset is asserted so every output reads zero.
                cmd_ready_o = reset_n_i;
                busy_o      = 1'b0;
                if (cmd_valid_i && (cmd_len_i != 32'd0)) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                jp_en_o = 1'b1;
                w_next  = S_GAP;
            end
            S_GAP: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (jp_done_i) begin
                    w_next = S_EMIT;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_EMIT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_next = (w_rem_next == 32'd0) ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rem  <= 32'd0;
            r_cnt  <= 32'd0;
            r_len  <= 32'd0;
            r_tms  <= 32'd0;
            r_tdi  <= 32'd0;
            r_tdo  <= 32'd0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_err <= 1'b0;
                        if (cmd_len_i == 32'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_rem <= cmd_len_i;
                        end
                    end
                end
                S_FETCH: begin
                    if (in_valid_i) begin
                        r_tms <= in_tms_i;
                        r_tdi <= in_tdi_i;
                        r_len <= w_chunk;
                    end
                end
                S_GAP: begin
                    r_cnt <= 32'd0;
                end
                S_WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (jp_done_i) begin
                        r_tdo <= jp_tdo_i & w_mask;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        r_rem <= 32'd0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_EMIT: begin
                    if (out_ready_i) begin
                        r_rem <= w_rem_next;
                        if (w_rem_next == 32'd0) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_tdo_o   = r_tdo;
    assign out_last_o  = (r_state == S_EMIT) && (r_rem <= 32'd32);
    assign jp_length_o = r_len;
    assign jp_tms_o    = r_tms;
    assign jp_tdi_o    = r_tdi;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_xvc_shift_ctrl.sv
// tb/tb_xvc_shift_ctrl.sv - directed self-checking bench for xvc_shift_ctrl
module tb_xvc_shift_ctrl;

    logic        clk_i;
    logic        reset_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_len_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_tms_i;
    logic [31:0] in_tdi_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_tdo_o;
    logic        out_last_o;
    logic        jp_en_o;
    logic [31:0] jp_length_o;
    logic [31:0] jp_tms_o;
    logic [31:0] jp_tdi_o;
    logic        jp_done_i;
    logic [31:0] jp_tdo_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_checks;
    int n_fails;

    xvc_shift_ctrl #(.C_DONE_TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_tms_i    (in_tms_i),
        .in_tdi_i    (in_tdi_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_tdo_o   (out_tdo_o),
        .out_last_o  (out_last_o),
        .jp_en_o     (jp_en_o),
        .jp_length_o (jp_length_o),
        .jp_tms_o    (jp_tms_o),
        .jp_tdi_o    (jp_tdi_o),
        .jp_done_i   (jp_done_i),
        .jp_tdo_i    (jp_tdo_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic send_cmd(input logic [31:0] len);
        int n;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_len_i   = len;
        n = 0;
        while (cmd_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fails++;
            $display("FAIL cmd_handshake_timeout: cmd_ready_o stayed %b, required 1", cmd_ready_o);
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] tms, input logic [31:0] tdi);
        int n;
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_tms_i   = tms;
        in_tdi_i   = tdi;
        n = 0;
        while (in_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fails++;
            $display("FAIL in_handshake_timeout: in_ready_o stayed %b, required 1", in_ready_o);
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    // One chunk: feed a word, answer the engine two WAIT cycles later, stall the output, then drain it.
    task automatic do_chunk(input logic [31:0] tms, input logic [31:0] tdi, input logic [31:0] etdo,
                            input int hold, output logic [31:0] len_s, output logic pulse_ok,
                            output logic [31:0] tdo_s, output logic last_s, output logic done_s,
                            output logic stable_s);
        logic [31:0] first;
        push_word(tms, tdi);
        len_s    = jp_length_o;
        pulse_ok = (jp_en_o === 1'b1);
        @(negedge clk_i);
        if (jp_en_o !== 1'b0) pulse_ok = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        jp_done_i = 1'b1;
        jp_tdo_i  = etdo;
        @(negedge clk_i);
        jp_done_i = 1'b0;
        jp_tdo_i  = 32'h0;
        first     = out_tdo_o;
        stable_s  = (out_valid_o === 1'b1);
        repeat (hold) begin
            @(negedge clk_i);
            if (out_valid_o !== 1'b1 || out_tdo_o !== first || jp_en_o !== 1'b0 || in_ready_o !== 1'b0)
                stable_s = 1'b0;
        end
        out_ready_i = 1'b1;
        tdo_s  = out_tdo_o;
        last_s = out_last_o;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        done_s = done_o;
    endtask

    task automatic test_reset;
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({cmd_ready_o, in_ready_o, out_valid_o, out_tdo_o, out_last_o, jp_en_o, jp_length_o,
             jp_tms_o, jp_tdi_o, busy_o, done_o, err_o} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: cmd_ready=%b busy=%b jp_en=%b out_valid=%b, required all 0",
                     cmd_ready_o, busy_o, jp_en_o, out_valid_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1/0", cmd_ready_o, busy_o);
        end
    endtask

    task automatic test_single;
        logic [31:0] len_s, tdo_s;
        logic pulse_ok, last_s, done_s, stable_s;
        send_cmd(32'd8);
        n_checks++;
        if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fails++;
            $display("FAIL single_fetch: busy=%b cmd_ready=%b in_ready=%b, required 1/0/1",
                     busy_o, cmd_ready_o, in_ready_o);
        end
        jp_done_i = 1'b1;
        jp_tdo_i  = 32'hFFFF_FFFF;
        @(negedge clk_i);
        jp_done_i = 1'b0;
        jp_tdo_i  = 32'h0;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fails++;
            $display("FAIL stray_done_ignored: in_ready=%b out_valid=%b, required 1/0", in_ready_o, out_valid_o);
        end
        do_chunk(32'h0000_00FF, 32'h0000_00A5, 32'hFFFF_FF3C, 0, len_s, pulse_ok, tdo_s, last_s, done_s, stable_s);
        n_checks++;
        if (len_s !== 32'd8 || pulse_ok !== 1'b1) begin
            n_fails++;
            $display("FAIL single_launch: jp_length=%0d pulse_ok=%b, required 8/1", len_s, pulse_ok);
        end
        n_checks++;
        if (tdo_s !== 32'h0000_003C || last_s !== 1'b1) begin
            n_fails++;
            $display("FAIL single_word: tdo=%h last=%b, required 0000003c/1", tdo_s, last_s);
        end
        n_checks++;
        if (done_s !== 1'b1 || busy_o !== 1'b0) begin
            n_fails++;
            $display("FAIL single_done: done=%b busy=%b, required 1/0", done_s, busy_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fails++;
            $display("FAIL single_done_pulse: done=%b one cycle later, required 0", done_o);
        end
    endtask

    task automatic test_multi;
        logic [31:0] len_s, tdo_s;
        logic pulse_ok, last_s, done_s, stable_s;
        logic [31:0] exp_len [3];
        logic [31:0] eng_tdo [3];
        logic [31:0] exp_tdo [3];
        exp_len = '{32'd32, 32'd32, 32'd6};
        eng_tdo = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFC5};
        exp_tdo = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0005};
        send_cmd(32'd70);
        for (int i = 0; i < 3; i++) begin
            do_chunk(32'hA0 + i, 32'h50 + i, eng_tdo[i], 0, len_s, pulse_ok, tdo_s, last_s, done_s, stable_s);
            n_checks++;
            if (len_s !== exp_len[i] || pulse_ok !== 1'b1) begin
                n_fails++;
                $display("FAIL multi_launch[%0d]: jp_length=%0d pulse_ok=%b, required %0d/1",
                         i, len_s, pulse_ok, exp_len[i]);
            end
            n_checks++;
            if (tdo_s !== exp_tdo[i] || last_s !== (i == 2) || done_s !== (i == 2)) begin
                n_fails++;
                $display("FAIL multi_word[%0d]: tdo=%h last=%b done=%b, required %h/%b/%b",
                         i, tdo_s, last_s, done_s, exp_tdo[i], (i == 2), (i == 2));
            end
        end
        n_checks++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            n_fails++;
            $display("FAIL multi_end: busy=%b in_ready=%b, required 0/0", busy_o, in_ready_o);
        end
    endtask

    task automatic test_zero;
        logic saw_bad;
        send_cmd(32'd0);
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fails++;
            $display("FAIL zero_done: done=%b busy=%b cmd_ready=%b, required 1/0/1", done_o, busy_o, cmd_ready_o);
        end
        saw_bad = 1'b0;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) saw_bad = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fails++;
            $display("FAIL zero_done_pulse: done=%b, required 0", done_o);
        end
        repeat (5) begin
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) saw_bad = 1'b1;
            @(negedge clk_i);
        end
        n_checks++;
        if (saw_bad !== 1'b0) begin
            n_fails++;
            $display("FAIL zero_no_stream: saw_stream=%b, required 0", saw_bad);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] len_s, tdo_s;
        logic pulse_ok, last_s, done_s, stable_s;
        send_cmd(32'd32);
        do_chunk(32'h0, 32'h1, 32'h8765_4321, 20, len_s, pulse_ok, tdo_s, last_s, done_s, stable_s);
        n_checks++;
        if (stable_s !== 1'b1) begin
            n_fails++;
            $display("FAIL backpressure_hold: stable=%b, required 1", stable_s);
        end
        n_checks++;
        if (tdo_s !== 32'h8765_4321 || last_s !== 1'b1 || done_s !== 1'b1) begin
            n_fails++;
            $display("FAIL backpressure_word: tdo=%h last=%b done=%b, required 87654321/1/1",
                     tdo_s, last_s, done_s);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] len_s, tdo_s;
        logic pulse_ok, last_s, done_s, stable_s;
        logic saw_done, saw_valid;
        int n;
        send_cmd(32'd40);
        push_word(32'h3, 32'h4);
        n = 0;
        saw_done  = 1'b0;
        saw_valid = 1'b0;
        while (err_o !== 1'b1 && n < 40) begin
            @(negedge clk_i);
            n++;
            if (done_o === 1'b1) saw_done = 1'b1;
            if (out_valid_o === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (n !== 18) begin
            n_fails++;
            $display("FAIL timeout_latency: err_o after %0d cycles from launch, required 18", n);
        end
        n_checks++;
        if (busy_o !== 1'b0 || saw_done !== 1'b0 || saw_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_abort: busy=%b saw_done=%b saw_valid=%b, required 0/0/0",
                     busy_o, saw_done, saw_valid);
        end
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (err_o !== 1'b1 || in_ready_o !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_sticky: err=%b in_ready=%b, required 1/0", err_o, in_ready_o);
        end
        send_cmd(32'd32);
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_err_clear: err=%b, required 0", err_o);
        end
        do_chunk(32'h5, 32'h6, 32'h0BAD_F00D, 0, len_s, pulse_ok, tdo_s, last_s, done_s, stable_s);
        n_checks++;
        if (tdo_s !== 32'h0BAD_F00D || done_s !== 1'b1) begin
            n_fails++;
            $display("FAIL timeout_recover: tdo=%h done=%b, required 0badf00d/1", tdo_s, done_s);
        end
    endtask

    task automatic test_done_at_timeout;
        send_cmd(32'd32);
        push_word(32'h7, 32'h8);
        repeat (17) @(negedge clk_i);
        jp_done_i = 1'b1;
        jp_tdo_i  = 32'hCAFE_F00D;
        @(negedge clk_i);
        jp_done_i = 1'b0;
        jp_tdo_i  = 32'h0;
        n_checks++;
        if (out_valid_o !== 1'b1 || err_o !== 1'b0 || out_tdo_o !== 32'hCAFE_F00D) begin
            n_fails++;
            $display("FAIL done_vs_timeout: out_valid=%b err=%b tdo=%h, required 1/0/cafef00d",
                     out_valid_o, err_o, out_tdo_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        n_checks++;
        if (done_o !== 1'b1) begin
            n_fails++;
            $display("FAIL done_vs_timeout_done: done=%b, required 1", done_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] len_s, tdo_s;
        logic pulse_ok, last_s, done_s, stable_s;
        send_cmd(32'd64);
        do_chunk(32'h1, 32'h2, 32'h0F0F_0F0F, 0, len_s, pulse_ok, tdo_s, last_s, done_s, stable_s);
        n_checks++;
        if (last_s !== 1'b0 || done_s !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid_chunk1: last=%b done=%b, required 0/0", last_s, done_s);
        end
        push_word(32'h9, 32'hA);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready_o, in_ready_o, out_valid_o, out_tdo_o, out_last_o, jp_en_o, jp_length_o,
             jp_tms_o, jp_tdi_o, busy_o, done_o, err_o} !== '0) begin
            n_fails++;
            $display("FAIL reset_mid_outputs: busy=%b tdo=%h len=%0d tms=%h, required all 0",
                     busy_o, out_tdo_o, jp_length_o, jp_tms_o);
        end
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (cmd_ready_o !== 1'b1 || done_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid_release: cmd_ready=%b done=%b, required 1/0", cmd_ready_o, done_o);
        end
        send_cmd(32'd32);
        do_chunk(32'hB, 32'hC, 32'h1357_9BDF, 0, len_s, pulse_ok, tdo_s, last_s, done_s, stable_s);
        n_checks++;
        if (len_s !== 32'd32 || tdo_s !== 32'h1357_9BDF || last_s !== 1'b1 || done_s !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_mid_recover: len=%0d tdo=%h last=%b done=%b, required 32/13579bdf/1/1",
                     len_s, tdo_s, last_s, done_s);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        reset_n_i   = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_len_i   = 32'h0;
        in_valid_i  = 1'b0;
        in_tms_i    = 32'h0;
        in_tdi_i    = 32'h0;
        out_ready_i = 1'b0;
        jp_done_i   = 1'b0;
        jp_tdo_i    = 32'h0;
        test_reset;
        test_single;
        test_multi;
        test_zero;
        test_backpressure;
        test_timeout;
        test_done_at_timeout;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
